// File: rtl/exec_pkg.sv
// Shared definitions for the execution cluster: ALU op codes, width defaults, lane states.
// No logic; constants and types only.
// Optional multiplier is enabled by defining FU_MUL_EN (see fu_lane / fu_exec_cluster).
package exec_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 6;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic {
        LANE_IDLE = 1'b0,
        LANE_BUSY = 1'b1
    } lane_state_t;

endpackage

// File: rtl/fu_lane.sv
// One execution lane: operand mux, ALU, latency counter and registered result broadcast.
// Latency: 1 cycle for ALU ops; LS_LATENCY for address ops; MUL_LATENCY for MUL when FU_MUL_EN is defined.
// Backpressure: ready drops while a multi-cycle op is in flight; issues seen then are dropped and flagged.
module fu_lane
    import exec_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int LS_LATENCY  = 2,
    parameter int MUL_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              is_ls,
    input  logic              alusrc,
    input  logic [3:0]        alu_type,
    input  logic [TAG_W-1:0]  rd_tag,
    input  logic [TAG_W-1:0]  rob_num,
    input  logic [DATA_W-1:0] rs1_val,
    input  logic [DATA_W-1:0] rs2_val,
    input  logic [DATA_W-1:0] imm,
    output logic              ready,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_val,
    output logic              done_valid,
    output logic [TAG_W-1:0]  done_num,
    output logic              drop
);

    lane_state_t       state;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] result;
    logic              accept;
    logic              is_nop;
    logic              multi;

    assign accept = issue_valid && ready;
    assign drop   = issue_valid && !ready;
    assign is_nop = !is_ls && (alu_type == OP_NOP);
`ifdef FU_MUL_EN
    assign multi  = is_ls || (alu_type == OP_MUL);
`else
    assign multi  = is_ls;
`endif

    // Operand select and ALU; address generation overrides the op code.
    always_comb begin
        opb    = alusrc ? imm : rs2_val;
        result = '0;
        case (alu_type)
            OP_ADD:  result = rs1_val + opb;
            OP_SUB:  result = rs1_val - opb;
            OP_AND:  result = rs1_val & opb;
            OP_OR:   result = rs1_val | opb;
            OP_XOR:  result = rs1_val ^ opb;
            OP_SLL:  result = rs1_val << opb[4:0];
            OP_SRL:  result = rs1_val >> opb[4:0];
            OP_SRA:  result = $signed(rs1_val) >>> opb[4:0];
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(rs1_val) < $signed(opb)};
            OP_SLTU: result = {{(DATA_W-1){1'b0}}, rs1_val < opb};
            OP_LUI:  result = imm;
`ifdef FU_MUL_EN
            OP_MUL:  result = rs1_val * opb;
`endif
            default: result = '0;
        endcase
        if (is_ls) begin
            result = rs1_val + imm;
        end
    end

    assign done_valid = wb_valid;

    // Lane FSM: capture result at accept, broadcast next cycle or after the latency countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LANE_IDLE;
            cnt      <= '0;
            ready    <= 1'b1;
            wb_valid <= 1'b0;
            wb_tag   <= '0;
            wb_val   <= '0;
            done_num <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                LANE_IDLE: begin
                    if (accept && !is_nop) begin
                        wb_tag   <= rd_tag;
                        wb_val   <= result;
                        done_num <= rob_num;
                        if (multi) begin
                            state <= LANE_BUSY;
                            ready <= 1'b0;
                            cnt   <= is_ls ? 8'(LS_LATENCY - 1) : 8'(MUL_LATENCY - 1);
                        end else begin
                            wb_valid <= 1'b1;
                        end
                    end
                end
                LANE_BUSY: begin
                    if (cnt == 8'd1) begin
                        state    <= LANE_IDLE;
                        ready    <= 1'b1;
                        wb_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= LANE_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fu_exec_cluster.sv
// Three execution lanes plus a registered load-return broadcast on wakeup port 4; FU_MUL_EN adds a multiplier.
// Latency: lanes as in fu_lane; port 4 is one cycle from ld_ret to wakeup_4.
// Backpressure: per-lane FUk_ready; an issue to a non-ready lane is dropped and sets sticky proto_err.
module fu_exec_cluster
    import exec_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int LS_LATENCY  = 2,
    parameter int MUL_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_FU1_valid,
    input  logic              issue_FU2_valid,
    input  logic              issue_FU3_valid,
    input  logic              issue_0_is_LS,
    input  logic              issue_1_is_LS,
    input  logic              issue_2_is_LS,
    input  logic              issue_0_alusrc,
    input  logic              issue_1_alusrc,
    input  logic              issue_2_alusrc,
    input  logic [3:0]        issue_0_alu_type,
    input  logic [3:0]        issue_1_alu_type,
    input  logic [3:0]        issue_2_alu_type,
    input  logic [TAG_W-1:0]  issue_0_rd_tag,
    input  logic [TAG_W-1:0]  issue_1_rd_tag,
    input  logic [TAG_W-1:0]  issue_2_rd_tag,
    input  logic [TAG_W-1:0]  issue_0_rob_num,
    input  logic [TAG_W-1:0]  issue_1_rob_num,
    input  logic [TAG_W-1:0]  issue_2_rob_num,
    input  logic [DATA_W-1:0] issue_0_rs1_val,
    input  logic [DATA_W-1:0] issue_1_rs1_val,
    input  logic [DATA_W-1:0] issue_2_rs1_val,
    input  logic [DATA_W-1:0] issue_0_rs2_val,
    input  logic [DATA_W-1:0] issue_1_rs2_val,
    input  logic [DATA_W-1:0] issue_2_rs2_val,
    input  logic [DATA_W-1:0] issue_0_imm,
    input  logic [DATA_W-1:0] issue_1_imm,
    input  logic [DATA_W-1:0] issue_2_imm,
    input  logic              ld_ret_valid,
    input  logic [TAG_W-1:0]  ld_ret_tag,
    input  logic [DATA_W-1:0] ld_ret_val,
    output logic              FU1_ready,
    output logic              FU2_ready,
    output logic              FU3_ready,
    output logic              wakeup_1_valid,
    output logic              wakeup_2_valid,
    output logic              wakeup_3_valid,
    output logic              wakeup_4_valid,
    output logic [TAG_W-1:0]  wakeup_1_tag,
    output logic [TAG_W-1:0]  wakeup_2_tag,
    output logic [TAG_W-1:0]  wakeup_3_tag,
    output logic [TAG_W-1:0]  wakeup_4_tag,
    output logic [DATA_W-1:0] wakeup_1_val,
    output logic [DATA_W-1:0] wakeup_2_val,
    output logic [DATA_W-1:0] wakeup_3_val,
    output logic [DATA_W-1:0] wakeup_4_val,
    output logic [2:0]        rob_done_valid,
    output logic [TAG_W-1:0]  rob_done_num_1,
    output logic [TAG_W-1:0]  rob_done_num_2,
    output logic [TAG_W-1:0]  rob_done_num_3,
    output logic              proto_err
);

    logic [2:0]             in_valid, in_ls, in_src;
    logic [2:0][3:0]        in_type;
    logic [2:0][TAG_W-1:0]  in_rd, in_rob;
    logic [2:0][DATA_W-1:0] in_rs1, in_rs2, in_imm;
    logic [2:0]             l_ready, l_wb_valid, l_done, l_drop;
    logic [2:0][TAG_W-1:0]  l_wb_tag, l_done_num;
    logic [2:0][DATA_W-1:0] l_wb_val;

    assign in_valid = {issue_FU3_valid, issue_FU2_valid, issue_FU1_valid};
    assign in_ls    = {issue_2_is_LS, issue_1_is_LS, issue_0_is_LS};
    assign in_src   = {issue_2_alusrc, issue_1_alusrc, issue_0_alusrc};
    assign in_type  = {issue_2_alu_type, issue_1_alu_type, issue_0_alu_type};
    assign in_rd    = {issue_2_rd_tag, issue_1_rd_tag, issue_0_rd_tag};
    assign in_rob   = {issue_2_rob_num, issue_1_rob_num, issue_0_rob_num};
    assign in_rs1   = {issue_2_rs1_val, issue_1_rs1_val, issue_0_rs1_val};
    assign in_rs2   = {issue_2_rs2_val, issue_1_rs2_val, issue_0_rs2_val};
    assign in_imm   = {issue_2_imm, issue_1_imm, issue_0_imm};

    for (genvar g = 0; g < 3; g++) begin : g_lane
        fu_lane #(
            .DATA_W(DATA_W), .TAG_W(TAG_W),
            .LS_LATENCY(LS_LATENCY), .MUL_LATENCY(MUL_LATENCY)
        ) u_lane (
            .clk(clk), .reset(reset),
            .issue_valid(in_valid[g]), .is_ls(in_ls[g]), .alusrc(in_src[g]),
            .alu_type(in_type[g]), .rd_tag(in_rd[g]), .rob_num(in_rob[g]),
            .rs1_val(in_rs1[g]), .rs2_val(in_rs2[g]), .imm(in_imm[g]),
            .ready(l_ready[g]), .wb_valid(l_wb_valid[g]), .wb_tag(l_wb_tag[g]),
            .wb_val(l_wb_val[g]), .done_valid(l_done[g]), .done_num(l_done_num[g]),
            .drop(l_drop[g])
        );
    end

    assign {FU3_ready, FU2_ready, FU1_ready}                = l_ready;
    assign {wakeup_3_valid, wakeup_2_valid, wakeup_1_valid} = l_wb_valid;
    assign {wakeup_3_tag, wakeup_2_tag, wakeup_1_tag}       = l_wb_tag;
    assign {wakeup_3_val, wakeup_2_val, wakeup_1_val}       = l_wb_val;
    assign rob_done_valid                                   = l_done;
    assign {rob_done_num_3, rob_done_num_2, rob_done_num_1} = l_done_num;

    // Register the external load return onto wakeup port 4.
    always_ff @(posedge clk) begin
        if (reset) begin
            wakeup_4_valid <= 1'b0;
            wakeup_4_tag   <= '0;
            wakeup_4_val   <= '0;
        end else begin
            wakeup_4_valid <= ld_ret_valid;
            if (ld_ret_valid) begin
                wakeup_4_tag <= ld_ret_tag;
                wakeup_4_val <= ld_ret_val;
            end
        end
    end

    // Sticky protocol error: any lane saw an issue while not ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (|l_drop) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fu_exec_cluster.sv
// Randomized and directed bench for fu_exec_cluster against a cycle-indexed event model.
// Honours FU_MUL_EN the same way as the design.
module tb_fu_exec_cluster;

    localparam int DW = 32;
    localparam int TW = 6;
    localparam int LS_LAT = 2;
    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]          vld, ls, asrc;
    logic [3:0]          op   [3];
    logic [TW-1:0]       rd   [3];
    logic [TW-1:0]       rob  [3];
    logic [DW-1:0]       rs1  [3];
    logic [DW-1:0]       rs2  [3];
    logic [DW-1:0]       imm  [3];
    logic                ld_vld;
    logic [TW-1:0]       ld_tag;
    logic [DW-1:0]       ld_val;

    logic [2:0]          rdy, done;
    logic [3:0]          wk_vld;
    logic [3:0][TW-1:0]  wk_tag;
    logic [3:0][DW-1:0]  wk_val;
    logic [2:0][TW-1:0]  dnum;
    logic                perr;

    fu_exec_cluster #(.DATA_W(DW), .TAG_W(TW), .LS_LATENCY(LS_LAT), .MUL_LATENCY(MUL_LAT)) dut (
        .clk(clk), .reset(reset),
        .issue_FU1_valid(vld[0]), .issue_FU2_valid(vld[1]), .issue_FU3_valid(vld[2]),
        .issue_0_is_LS(ls[0]), .issue_1_is_LS(ls[1]), .issue_2_is_LS(ls[2]),
        .issue_0_alusrc(asrc[0]), .issue_1_alusrc(asrc[1]), .issue_2_alusrc(asrc[2]),
        .issue_0_alu_type(op[0]), .issue_1_alu_type(op[1]), .issue_2_alu_type(op[2]),
        .issue_0_rd_tag(rd[0]), .issue_1_rd_tag(rd[1]), .issue_2_rd_tag(rd[2]),
        .issue_0_rob_num(rob[0]), .issue_1_rob_num(rob[1]), .issue_2_rob_num(rob[2]),
        .issue_0_rs1_val(rs1[0]), .issue_1_rs1_val(rs1[1]), .issue_2_rs1_val(rs1[2]),
        .issue_0_rs2_val(rs2[0]), .issue_1_rs2_val(rs2[1]), .issue_2_rs2_val(rs2[2]),
        .issue_0_imm(imm[0]), .issue_1_imm(imm[1]), .issue_2_imm(imm[2]),
        .ld_ret_valid(ld_vld), .ld_ret_tag(ld_tag), .ld_ret_val(ld_val),
        .FU1_ready(rdy[0]), .FU2_ready(rdy[1]), .FU3_ready(rdy[2]),
        .wakeup_1_valid(wk_vld[0]), .wakeup_2_valid(wk_vld[1]),
        .wakeup_3_valid(wk_vld[2]), .wakeup_4_valid(wk_vld[3]),
        .wakeup_1_tag(wk_tag[0]), .wakeup_2_tag(wk_tag[1]),
        .wakeup_3_tag(wk_tag[2]), .wakeup_4_tag(wk_tag[3]),
        .wakeup_1_val(wk_val[0]), .wakeup_2_val(wk_val[1]),
        .wakeup_3_val(wk_val[2]), .wakeup_4_val(wk_val[3]),
        .rob_done_valid(done),
        .rob_done_num_1(dnum[0]), .rob_done_num_2(dnum[1]), .rob_done_num_3(dnum[2]),
        .proto_err(perr)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: one scheduled completion per lane, keyed by the cycle it must appear in.
    int          cyc = 0;
    int          free_at  [3];
    int          due_cyc  [3];
    logic [TW-1:0] due_tag [3];
    logic [TW-1:0] due_rob [3];
    logic [DW-1:0] due_val [3];
    int          ld_due;
    logic [TW-1:0] ld_etag;
    logic [DW-1:0] ld_eval;
    bit          perr_exp;

    function automatic logic [DW-1:0] ref_result(input int k);
        logic [DW-1:0] b;
        int unsigned   sh;
        b  = asrc[k] ? imm[k] : rs2[k];
        sh = b % 32;
        if (ls[k]) return rs1[k] + imm[k];
        case (int'(op[k]))
            1:  return rs1[k] + b;
            2:  return rs1[k] - b;
            3:  return rs1[k] & b;
            4:  return rs1[k] | b;
            5:  return rs1[k] ^ b;
            6:  return rs1[k] << sh;
            7:  return rs1[k] >> sh;
            8:  return DW'($signed(rs1[k]) >>> sh);
            9:  return ($signed(rs1[k]) < $signed(b)) ? 1 : 0;
            10: return (rs1[k] < b) ? 1 : 0;
            11: return imm[k];
`ifdef FU_MUL_EN
            12: return DW'(64'(rs1[k]) * 64'(b));
`endif
            default: return 0;
        endcase
    endfunction

    function automatic int ref_latency(input int k);
        if (ls[k]) return LS_LAT;
`ifdef FU_MUL_EN
        if (op[k] == 4'd12) return MUL_LAT;
`endif
        return 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            free_at[k] = 0;
            due_cyc[k] = -1;
        end
        ld_due = -1;
        perr_exp = 0;
    endtask

    // Apply the inputs present during cycle 'cyc' to the model.
    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (vld[k]) begin
                if (cyc < free_at[k]) begin
                    perr_exp = 1;
                end else if (ls[k] || op[k] != 4'd0) begin
                    int lat = ref_latency(k);
                    free_at[k] = cyc + lat;
                    due_cyc[k] = cyc + lat;
                    due_tag[k] = rd[k];
                    due_rob[k] = rob[k];
                    due_val[k] = ref_result(k);
                end
            end
        end
        if (ld_vld) begin
            ld_due  = cyc + 1;
            ld_etag = ld_tag;
            ld_eval = ld_val;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            bit fire = (due_cyc[k] == cyc);
            check($sformatf("ready%0d", k + 1), rdy[k], cyc >= free_at[k]);
            check($sformatf("wk%0d_vld", k + 1), wk_vld[k], fire);
            check($sformatf("done%0d", k + 1), done[k], fire);
            if (fire) begin
                check($sformatf("wk%0d_tag", k + 1), wk_tag[k], due_tag[k]);
                check($sformatf("wk%0d_val", k + 1), wk_val[k], due_val[k]);
                check($sformatf("dnum%0d", k + 1), dnum[k], due_rob[k]);
            end
        end
        check("wk4_vld", wk_vld[3], ld_due == cyc);
        if (ld_due == cyc) begin
            check("wk4_tag", wk_tag[3], ld_etag);
            check("wk4_val", wk_val[3], ld_eval);
        end
        check("proto_err", perr, perr_exp);
    endtask

    task automatic idle_inputs();
        vld = '0; ls = '0; asrc = '0; ld_vld = 0; ld_tag = '0; ld_val = '0;
        for (int k = 0; k < 3; k++) begin
            op[k] = '0; rd[k] = '0; rob[k] = '0; rs1[k] = '0; rs2[k] = '0; imm[k] = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_all();
        idle_inputs();
    endtask

    task automatic iss(input int k, input bit l, input bit s, input int o, input int t,
                       input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] i);
        vld[k] = 1; ls[k] = l; asrc[k] = s; op[k] = 4'(o); rd[k] = TW'(t); rob[k] = TW'(r);
        rs1[k] = a; rs2[k] = b; imm[k] = i;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1;
        step(); step();
        reset = 0;
        check("rst_rdy", rdy, 3'b111);
        check("rst_wk_vld", wk_vld, 4'b0000);
        check("rst_vals", {wk_val[0], wk_val[3]}, 64'd0);
        check("rst_perr", perr, 1'b0);

        // ADD 5+7 on FU1
        iss(0, 0, 0, 1, 12, 3, 5, 7, 0);
        step();
        check("t1_val", wk_val[0], 12);
        check("t1_done", done, 3'b001);
        check("t1_num", dnum[0], 3);

        // SUB with immediate, SRA of sign bit, SLTU against all-ones
        iss(1, 0, 1, 2, 1, 1, 10, 0, 3); step(); check("t2_sub", wk_val[1], 7);
        iss(1, 0, 0, 8, 2, 2, 32'h8000_0000, 4, 0); step(); check("t2_sra", wk_val[1], 32'hF800_0000);
        iss(1, 0, 0, 10, 3, 3, 1, 32'hFFFF_FFFF, 0); step(); check("t2_sltu", wk_val[1], 1);

        // Address op on FU3
        iss(2, 1, 0, 0, 20, 5, 32'h100, 0, 8);
        step(); check("t3_busy", rdy[2], 0);
        step(); check("t3_val", wk_val[2], 32'h108); check("t3_rdy", rdy[2], 1);

        // All four ports in one cycle
        iss(0, 0, 0, 1, 10, 1, 1, 2, 0);
        iss(1, 0, 0, 1, 11, 2, 3, 4, 0);
        iss(2, 0, 0, 1, 12, 3, 5, 6, 0);
        ld_vld = 1; ld_tag = 40; ld_val = 32'hDEAD;
        step();
        check("t4_all", wk_vld, 4'b1111);
        check("t4_tag4", wk_tag[3], 40);

        // Issue to busy FU3
        iss(2, 1, 0, 0, 21, 6, 32'h200, 0, 4);
        step();
        iss(2, 0, 0, 1, 22, 7, 1, 1, 0);
        step();
        check("t5_perr", perr, 1);
        check("t5_val", wk_val[2], 32'h204);
        step(); check("t5_hold", perr, 1);

        // Reset in the second cycle of an address op
        iss(2, 1, 0, 0, 23, 8, 32'h300, 0, 4);
        step();
        reset = 1; step(); reset = 0;
        step(); check("t6_nowk", wk_vld[2], 0); check("t6_rdy", rdy[2], 1);

`ifdef FU_MUL_EN
        iss(0, 0, 0, 12, 30, 9, 6, 7, 0);
        step(); step(); check("mul_busy", rdy[0], 0);
        step(); check("mul_val", wk_val[0], 42);
`endif

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    logic [DW-1:0] a, b, i;
                    a = $urandom(); b = $urandom(); i = $urandom();
                    if ($urandom_range(0, 3) == 0) b = DW'($urandom_range(0, 40));
                    iss(k, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63), a, b, i);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                ld_vld = 1; ld_tag = TW'($urandom()); ld_val = $urandom();
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
            reset = 0;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
